// File: rtl/mdu.sv
// mdu -- multi-cycle RV64M multiply/divide unit for the execute stage.
//
// One operation is in flight at a time. A request is accepted on a rising
// edge with in_valid && in_ready && !flush. Multiplies finish MUL_STAGES
// cycles later. Divides use a restoring shift/subtract loop that produces
// one quotient bit per cycle. Divide-by-zero and signed overflow are
// resolved at accept and finish in one cycle.
//
// Parameters
//   XLEN        operand/result width, 32 or 64 (is_word ignored when 32)
//   MUL_STAGES  multiply latency in cycles, >= 1
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in_valid    request present
//   in_ready    unit can accept (high exactly in IDLE), registered
//   op          funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   is_word     W variant (ops 0,4,5,6,7)
//   srca, srcb  rs1 / rs2 values
//   flush       kill any in-flight or completed op, highest priority
//   out_valid   result valid (high exactly in DONE), registered
//   out_ready   consumer takes the result
//   out_result  registered result, held stable while in DONE
module mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_MAX = (MUL_STAGES > XLEN) ? MUL_STAGES : XLEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Left shift that moves a 32-bit dividend to the top of the quotient
  // register, so word divides need only 32 iterations.
  localparam int WSH     = XLEN - 32;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] N_FULL   = CW'(XLEN);
  localparam logic [CW-1:0] N_WORD   = CW'(32);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Reduce an operand to its word form: low 32 bits, sign- or zero-extended.
  function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] v,
                                             input logic w,
                                             input logic sgn);
    logic [XLEN-1:0] r;
    if (!w) begin
      r = v;
    end else if (sgn) begin
      r = sext32(v[31:0]);
    end else begin
      r = XLEN'(v[31:0]);
    end
    return r;
  endfunction

  state_t state_r, state_n;

  logic            in_ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] res_r;
  logic [2:0]      op_r;
  logic            word_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic [CW-1:0]   cnt_r;

  logic            word_in_s;
  logic            accept_s;

  assign word_in_s  = is_word & (XLEN == 64);
  assign accept_s   = (state_r == ST_IDLE) & in_valid & ~flush;
  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = res_r;

  // ---------------------------------------------------------------------
  // Multiplier. In IDLE it sees the incoming request (needed when
  // MUL_STAGES is 1); afterwards the latched operands hold it stable, so
  // retiming can spread the product over the MUL_STAGES cycles.
  // ---------------------------------------------------------------------
  logic [2:0]        mop_s;
  logic              mword_s;
  logic [XLEN-1:0]   ma_s, mb_s;
  logic              ma_sgn_s, mb_sgn_s;
  logic [2*XLEN-1:0] pa_s, pb_s, prod_s;
  logic [XLEN-1:0]   mul_res_s;

  // Multiplier operand selection, extension and result selection.
  always_comb begin
    mop_s   = op_r;
    mword_s = word_r;
    ma_s    = a_r;
    mb_s    = b_r;
    if (state_r == ST_IDLE) begin
      mop_s   = op;
      mword_s = word_in_s;
      ma_s    = srca;
      mb_s    = srcb;
    end else begin
      mop_s   = op_r;
      mword_s = word_r;
    end
    ma_sgn_s = (mop_s == 3'd1) | (mop_s == 3'd2);
    mb_sgn_s = (mop_s == 3'd1);
    pa_s     = {{XLEN{ma_sgn_s & ma_s[XLEN-1]}}, ma_s};
    pb_s     = {{XLEN{mb_sgn_s & mb_s[XLEN-1]}}, mb_s};
    // Low 2*XLEN bits of the product are exact for all signedness mixes.
    prod_s   = pa_s * pb_s;
    case (mop_s)
      3'd0:                mul_res_s = mword_s ? sext32(prod_s[31:0]) : prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    mul_res_s = prod_s[2*XLEN-1:XLEN];
      default:             mul_res_s = prod_s[XLEN-1:0];
    endcase
  end

  // ---------------------------------------------------------------------
  // Divide set-up at accept: word narrowing, magnitudes, special cases.
  // ---------------------------------------------------------------------
  logic            d_sgn_s;
  logic [XLEN-1:0] da_s, db_s, amag_s, bmag_s, most_neg_s;
  logic            a_neg_s, b_neg_s, b_zero_s, ovf_s, div_special_s;
  logic [XLEN-1:0] spec_raw_s, spec_res_s, quo_init_s;

  // Divide operand preparation and special-case results.
  always_comb begin
    d_sgn_s    = ~op[0];
    da_s       = narrow(srca, word_in_s, d_sgn_s);
    db_s       = narrow(srcb, word_in_s, d_sgn_s);
    a_neg_s    = d_sgn_s & da_s[XLEN-1];
    b_neg_s    = d_sgn_s & db_s[XLEN-1];
    amag_s     = a_neg_s ? (-da_s) : da_s;
    bmag_s     = b_neg_s ? (-db_s) : db_s;
    most_neg_s = word_in_s ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero_s   = (db_s == {XLEN{1'b0}});
    ovf_s      = d_sgn_s & (da_s == most_neg_s) & (db_s == {XLEN{1'b1}});
    div_special_s = op[2] & (b_zero_s | ovf_s);
    if (b_zero_s) begin
      spec_raw_s = op[1] ? da_s : {XLEN{1'b1}};
    end else begin
      spec_raw_s = op[1] ? {XLEN{1'b0}} : da_s;
    end
    // Unsigned word remainders by zero still return a sign-extended word.
    spec_res_s = word_in_s ? sext32(spec_raw_s[31:0]) : spec_raw_s;
    quo_init_s = word_in_s ? (amag_s << WSH) : amag_s;
  end

  // ---------------------------------------------------------------------
  // Restoring divide step: shift {rem, quo} left, trial-subtract divisor.
  // ---------------------------------------------------------------------
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic            qbit_s;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s, qfix_s, rfix_s, div_raw_s, div_res_s;

  // One quotient bit per cycle plus the sign fix-up for the last step.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[XLEN-1]};
    diff_s    = rem_sh_s - {1'b0, dvs_r};
    qbit_s    = ~diff_s[XLEN];
    rem_nx_s  = qbit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
    quo_nx_s  = {quo_r[XLEN-2:0], qbit_s};
    qfix_s    = neg_q_r ? (-quo_nx_s) : quo_nx_s;
    rfix_s    = neg_r_r ? (-rem_nx_s) : rem_nx_s;
    div_raw_s = op_r[1] ? rfix_s : qfix_s;
    div_res_s = word_r ? sext32(div_raw_s[31:0]) : div_raw_s;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_n = state_r;
    if (flush) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            if (!op[2]) begin
              state_n = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
            end else if (div_special_s) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_DIV;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_ONE) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_MUL;
          end
        end
        ST_DIV: begin
          if (cnt_r == CNT_ONE) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_DIV;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == ST_IDLE);
      out_valid_r <= (state_n == ST_DONE);
    end
  end

  // Operand capture, iteration counter, divide registers and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_r   <= {XLEN{1'b0}};
      op_r    <= 3'd0;
      word_r  <= 1'b0;
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      quo_r   <= {XLEN{1'b0}};
      dvs_r   <= {XLEN{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else if (flush) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r   <= op;
            word_r <= word_in_s;
            a_r    <= srca;
            b_r    <= srcb;
            if (!op[2]) begin
              cnt_r <= MUL_LOAD;
              if (MUL_STAGES == 1) begin
                res_r <= mul_res_s;
              end
            end else if (div_special_s) begin
              cnt_r <= CNT_ZERO;
              res_r <= spec_res_s;
            end else begin
              rem_r   <= {XLEN{1'b0}};
              quo_r   <= quo_init_s;
              dvs_r   <= bmag_s;
              neg_q_r <= d_sgn_s & (a_neg_s ^ b_neg_s);
              neg_r_r <= a_neg_s;
              cnt_r   <= word_in_s ? N_WORD : N_FULL;
            end
          end
        end
        ST_MUL: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            res_r <= mul_res_s;
          end
        end
        ST_DIV: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            res_r <= div_res_s;
          end
        end
        ST_DONE: begin
          cnt_r <= CNT_ZERO;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (XLEN=64, MUL_STAGES=3).
module tb_mdu;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        is_word;
  logic [63:0] srca;
  logic [63:0] srcb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int checks = 0;
  int fails  = 0;

  mdu #(.XLEN(64), .MUL_STAGES(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .srca(srca), .srcb(srcb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for out_valid, report latency in
  // cycles after the accept edge; optionally complete the handshake.
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic rel,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; is_word = w; srca = a; srcb = b; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = out_result;
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 64'h0) begin fails++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  o [5] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULH};
    logic [63:0] a [5] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000};
    logic [63:0] b [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'd4};
    logic [63:0] e [5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(o[i], 1'b0, a[i], b[i], 1'b1, res, lat);
      checks++; if (res !== e[i]) begin fails++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, e[i]); end
      checks++; if (lat != 3) begin fails++; $display("FAIL mul_latency[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  o [6] = '{OP_DIV, OP_REM, OP_REMU, OP_DIVU, OP_REM, OP_DIVU};
    logic [63:0] a [6] = '{64'd100, 64'd100, 64'd100, 64'd100,
                           64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] b [6] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                           64'd7, 64'd7, 64'd7, 64'd3};
    logic [63:0] e [6] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 64'd2, 64'd14,
                           64'hFFFF_FFFF_FFFF_FFFE, 64'h5555_5555_5555_5555};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(o[i], 1'b0, a[i], b[i], 1'b1, res, lat);
      checks++; if (res !== e[i]) begin fails++; $display("FAIL div_result[%0d]: got %h want %h", i, res, e[i]); end
      checks++; if (lat != 65) begin fails++; $display("FAIL div_latency[%0d]: got %0d want 65", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  o [7] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REMU};
    logic        w [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] a [7] = '{64'd1234, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                           64'h0000_0000_8000_0000, 64'd5, 64'h0000_0000_8000_0005};
    logic [63:0] b [7] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0};
    logic [63:0] e [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'h0,
                           64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_8000_0005};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(o[i], w[i], a[i], b[i], 1'b1, res, lat);
      checks++; if (res !== e[i]) begin fails++; $display("FAIL special_result[%0d]: got %h want %h", i, res, e[i]); end
      checks++; if (lat != 1) begin fails++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_word();
    logic [2:0]  o [4] = '{OP_MUL, OP_DIVU, OP_REM, OP_DIV};
    logic [63:0] a [4] = '{64'hABCD_0000_7FFF_FFFF, 64'hFFFF_FFFF_0000_0010,
                           64'h0000_0000_FFFF_FFF9, 64'h0000_0001_0000_0014};
    logic [63:0] b [4] = '{64'd2, 64'd4, 64'd2, 64'h0000_0000_FFFF_FFFB};
    logic [63:0] e [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFC};
    int          el [4] = '{3, 33, 33, 33};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(o[i], 1'b1, a[i], b[i], 1'b1, res, lat);
      checks++; if (res !== e[i]) begin fails++; $display("FAIL word_result[%0d]: got %h want %h", i, res, e[i]); end
      checks++; if (lat != el[i]) begin fails++; $display("FAIL word_latency[%0d]: got %0d want %0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    do_op(OP_MUL, 1'b0, 64'd6, 64'd7, 1'b0, res, lat);
    checks++; if (res !== 64'd42) begin fails++; $display("FAIL bp_result: got %h want %h", res, 64'd42); end
    checks++; if (lat != 3) begin fails++; $display("FAIL bp_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_result !== 64'd42) begin fails++; $display("FAIL bp_hold_result[%0d]: got %h want %h", i, out_result, 64'd42); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    // Accepted at the end of the cycle right after the handshake.
    do_op(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, res, lat);
    checks++; if (res !== 64'd1) begin fails++; $display("FAIL b2b_result: got %h want %h", res, 64'd1); end
    checks++; if (lat != 3) begin fails++; $display("FAIL b2b_latency: got %0d want 3", lat); end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV; is_word = 1'b0; srca = 64'd1000; srcb = 64'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    do_op(OP_MUL, 1'b0, 64'd9, 64'd9, 1'b1, res, lat);
    checks++; if (res !== 64'd81) begin fails++; $display("FAIL flush_then_mul: got %h want %h", res, 64'd81); end
    checks++; if (lat != 3) begin fails++; $display("FAIL flush_then_mul_latency: got %0d want 3", lat); end
  endtask

  task automatic test_async_reset();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; is_word = 1'b0; srca = 64'd3; srcb = 64'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b want 0", in_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 64'h0) begin fails++; $display("FAIL areset_out_result: got %h want 0", out_result); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL areset_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_flush_accept();
    logic [63:0] res;
    int lat;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = OP_DIV; is_word = 1'b0; srca = 64'd10; srcb = 64'd0;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_accept_in_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL flush_accept_blocked: got %0d valid cycles want 0", seen); end
    do_op(OP_DIV, 1'b0, 64'd10, 64'd0, 1'b1, res, lat);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL flush_accept_after: got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (lat != 1) begin fails++; $display("FAIL flush_accept_after_latency: got %0d want 1", lat); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; is_word = 1'b0;
    srca = 64'h0; srcb = 64'h0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_word();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_flush_accept();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle integer multiply/divide unit for the RV64 pipeline's execute stage. It implements all RV64M operations, including the W variants, behind a valid/ready handshake. The single-cycle ALU path keeps every non-M instruction; the execute stage steers M-extension ops here and stalls until the result returns. Operand width and multiplier latency are parametrised.

## Interface
- XLEN, default 64: operand/result width; must be 32 or 64. With XLEN=32, is_word is ignored and treated as 0.
- MUL_STAGES, default 3: multiply latency in cycles; must be ≥1.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high exactly when state is IDLE.
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- is_word  in  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW); only op 0,4,5,6,7 are legal with it.
- srca  in  XLEN  rs1 value.
- srcb  in  XLEN  rs2 value.
- flush  in  1  kill any in-flight or completed op.
- out_valid  out  1  result valid; high exactly in DONE.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result, registered.

## Operation
- Accept: a request is taken on a rising edge where in_valid && in_ready && !flush. At that edge the unit latches op, is_word, and the operands.
- States:
  - IDLE → MUL when accepting op 0–3.
  - IDLE → DIV when accepting a normal op 4–7.
  - IDLE → DONE when accepting a divide special case.
  - MUL → DONE when the counter reaches 0.
  - DIV → DONE after N iterations.
  - DONE → IDLE on out_ready.
- Word ops: operands are the low 32 bits; signed ops sign-extend and unsigned ops zero-extend. The result is the 32-bit result sign-extended to 64 bits. N is 32 for word ops and XLEN otherwise.
- Multiply: forms the 2N-bit product. Signedness: MULH is s×s, MULHSU is s×u, MULHU is u×u.
  - MUL/MULW return the low N bits.
  - MULH* return the high XLEN bits.
  - Internal pipeline depth is MUL_STAGES. A down-counter is loaded with MUL_STAGES-1 at accept.
- Divide: restoring algorithm, 1 quotient bit per cycle, on operand magnitudes.
  - Quotient sign = sign(a) XOR sign(b), for signed ops.
  - Remainder sign = sign(a).
  - Sign fix-up is applied in the last iteration cycle.
- Special cases, detected at accept, no iterations:
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
  - Signed overflow (most-negative / -1, at width N): quotient = dividend, remainder = 0.
  - Both apply after word truncation and before sign extension.
- flush: highest priority. On the next edge the state goes to IDLE and out_valid deasserts; no result is produced. A flush in the same cycle as in_valid blocks the accept.
- out_result holds its value while in DONE. Its value outside DONE is don't-care except at reset.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, counters 0. Reset mid-operation discards everything.
- Latency, with accept at edge ending cycle T:
  - MUL: out_valid high in cycle T+MUL_STAGES.
  - DIV, normal: out_valid high in cycle T+N+1 (T+65 for 64-bit, T+33 for W).
  - DIV special case: out_valid high in cycle T+1.
- Throughput: one op in flight. in_ready is low from T+1 until the cycle after DONE is left.
- Backpressure: out_valid and out_result stay stable until out_ready is sampled high. Dropping out_valid without out_ready is illegal except on flush/reset.
- out_ready is ignored outside DONE.
- No combinational path from in_valid to out_valid or from out_ready to in_ready. in_ready goes high the cycle after the handshake.

## Test plan
- MUL, srca=7, srcb=-3 (0xFFFF_FFFF_FFFF_FFFD), MUL_STAGES=3 → out_valid at T+3, out_result=0xFFFF_FFFF_FFFF_FFEB. MULHU with all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULHSU with -1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV 100 / -7 → quotient 0xFFFF_FFFF_FFFF_FFF2 (-14) at T+65. REM 100 % -7 → 2. REMU 100 % 7 → 2.
- Specials, each with out_valid at T+1:
  - DIVU x / 0 → all ones.
  - REM 5 % 0 → 5.
  - DIV 0x8000_0000_0000_0000 / -1 → same value.
  - REM of the same operands → 0.
  - DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- W variants: MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE. DIVUW 0xFFFF_FFFF_0000_0010 / 4 → 4 at T+33.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable and in_ready=0. Then assert out_ready → in_ready=1 next cycle, and a back-to-back accept works.
- Flush and reset: flush at DIV iteration 10 → IDLE next cycle with no out_valid; a new MUL then gives a correct result. Asynchronous reset mid-MUL → out_valid=0 and in_ready=1 immediately. Flush with in_valid in the same cycle → no accept.
